// File: rtl/alu_issue_ctrl.sv
// Issue controller between RX and decode/ALU: command FIFO, opcode filter,
// credit-gated issue and result FIFO toward TX.
module alu_issue_ctrl #(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int RES_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_op,
  input  logic [7:0]                     in_a1,
  input  logic [7:0]                     in_a2,
  input  logic [7:0]                     in_b1,
  input  logic [7:0]                     in_b2,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [7:0]                     cmd_op,
  output logic [7:0]                     cmd_a1,
  output logic [7:0]                     cmd_a2,
  output logic [7:0]                     cmd_b1,
  output logic [7:0]                     cmd_b2,
  input  logic                           res_valid,
  input  logic [RES_W-1:0]               res_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RES_W-1:0]               out_data,
  output logic [$clog2(RES_DEPTH+1)-1:0] inflight,
  output logic [7:0]                     err_cnt,
  output logic                           proto_err
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int IW  = $clog2(RES_DEPTH+1);

  logic [39:0]      cmd_mem [CMD_DEPTH];
  logic [RES_W-1:0] res_mem [RES_DEPTH];

  logic [CAW:0]  cw_q, cw_d, cr_q, cr_d;
  logic [RAW:0]  rw_q, rw_d, rr_q, rr_d;
  logic [IW-1:0] inf_q, inf_d;
  logic [7:0]    err_q, err_d;
  logic          perr_q, perr_d;

  logic          cmd_empty, cmd_full, res_empty;
  logic [RAW:0]  res_cnt;
  logic [IW:0]   used;
  logic          credit_ok, legal;
  logic          push, drop, issue, res_ok, pop;

  assign cmd_empty = cw_q == cr_q;
  assign cmd_full  = (cw_q[CAW] != cr_q[CAW]) &&
                     (cw_q[CAW-1:0] == cr_q[CAW-1:0]);
  assign res_empty = rw_q == rr_q;
  assign res_cnt   = rw_q - rr_q;

  // Outstanding work plus buffered results must leave room for one more.
  assign used      = {1'b0, inf_q} + (IW+1)'(res_cnt);
  assign credit_ok = used < (IW+1)'(RES_DEPTH);

  assign legal  = (in_op != 8'h00) && (in_op < 8'h10);
  assign push   = in_valid && in_ready && legal;
  assign drop   = in_valid && in_ready && !legal;
  assign issue  = cmd_valid && cmd_ready;
  assign res_ok = res_valid && (inf_q != '0);
  assign pop    = out_valid && out_ready;

  assign in_ready  = !cmd_full;
  assign cmd_valid = !cmd_empty && credit_ok;
  assign {cmd_op, cmd_a1, cmd_a2, cmd_b1, cmd_b2} = cmd_mem[cr_q[CAW-1:0]];
  assign out_valid = !res_empty;
  assign out_data  = res_mem[rr_q[RAW-1:0]];
  assign inflight  = inf_q;
  assign err_cnt   = err_q;
  assign proto_err = perr_q;

  always_comb begin
    cw_d   = cw_q + (CAW+1)'(push);
    cr_d   = cr_q + (CAW+1)'(issue);
    rw_d   = rw_q + (RAW+1)'(res_ok);
    rr_d   = rr_q + (RAW+1)'(pop);
    inf_d  = inf_q;
    err_d  = err_q;
    perr_d = perr_q | (res_valid && (inf_q == '0));
    if (issue && !res_ok) inf_d = inf_q + 1'b1;
    if (!issue && res_ok) inf_d = inf_q - 1'b1;
    if (drop && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q   <= '0;
      cr_q   <= '0;
      rw_q   <= '0;
      rr_q   <= '0;
      inf_q  <= '0;
      err_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      cw_q   <= cw_d;
      cr_q   <= cr_d;
      rw_q   <= rw_d;
      rr_q   <= rr_d;
      inf_q  <= inf_d;
      err_q  <= err_d;
      perr_q <= perr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      cmd_mem[cw_q[CAW-1:0]] <= {in_op, in_a1, in_a2, in_b1, in_b2};
    if (res_ok)
      res_mem[rw_q[RAW-1:0]] <= res_data;
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_alu_issue_ctrl;
  localparam int CD = 4;
  localparam int RD = 4;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_op = '0, in_a1 = '0, in_a2 = '0, in_b1 = '0, in_b2 = '0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [7:0]    cmd_op, cmd_a1, cmd_a2, cmd_b1, cmd_b2;
  logic          res_valid = 1'b0;
  logic [RW-1:0] res_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic [2:0]    inflight;
  logic [7:0]    err_cnt;
  logic          proto_err;

  alu_issue_ctrl #(.CMD_DEPTH(CD), .RES_DEPTH(RD), .RES_W(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a1(in_a1), .in_a2(in_a2),
    .in_b1(in_b1), .in_b2(in_b2),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2),
    .cmd_b1(cmd_b1), .cmd_b2(cmd_b2),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight), .err_cnt(err_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [39:0]   mq[$];
  logic [RW-1:0] rq[$];
  int            minf = 0;
  int            merr = 0;
  bit            mproto = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_cmd_valid();
    return (mq.size() > 0) && (minf + rq.size() < RD);
  endfunction

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(mq.size() < CD));
    chk("cmd_valid", 64'(cmd_valid), 64'(m_cmd_valid()));
    if (mq.size() > 0)
      chk("cmd_fields", 64'({cmd_op, cmd_a1, cmd_a2, cmd_b1, cmd_b2}),
          64'(mq[0]));
    chk("out_valid", 64'(out_valid), 64'(rq.size() > 0));
    if (rq.size() > 0)
      chk("out_data", 64'(out_data), 64'(rq[0]));
    chk("inflight", 64'(inflight), 64'(minf));
    chk("err_cnt", 64'(err_cnt), 64'(merr));
    chk("proto_err", 64'(proto_err), 64'(mproto));
  endtask

  // One clock: drive at negedge, advance model at posedge, check at negedge.
  task automatic step(input bit iv, input logic [39:0] ins, input bit cr,
                      input bit rv, input logic [RW-1:0] rd, input bit orr);
    bit acc, iss, pp, rok, lg;
    in_valid = iv;
    {in_op, in_a1, in_a2, in_b1, in_b2} = ins;
    cmd_ready = cr;
    res_valid = rv;
    res_data = rd;
    out_ready = orr;
    acc = iv && (mq.size() < CD);
    lg  = (ins[39:32] >= 8'h01) && (ins[39:32] <= 8'h0F);
    iss = m_cmd_valid() && cr;
    pp  = (rq.size() > 0) && orr;
    rok = rv && (minf > 0);
    @(posedge clk);
    if (iss) void'(mq.pop_front());
    if (acc && lg) mq.push_back(ins);
    if (acc && !lg && merr < 255) merr++;
    if (pp) void'(rq.pop_front());
    if (rok) rq.push_back(rd);
    if (rv && minf == 0) mproto = 1'b1;
    minf = minf + int'(iss) - int'(rok);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit cr, input bit orr);
    step(1'b0, 40'h0, cr, 1'b0, '0, orr);
  endtask

  task automatic drain();
    repeat (30) step(1'b0, 40'h0, 1'b1, minf > 0, $urandom, 1'b1);
  endtask

  function automatic logic [39:0] rnd_ins();
    logic [7:0] op;
    if ($urandom_range(3) != 0) op = 8'($urandom_range(15, 1));
    else op = ($urandom_range(1) != 0) ? 8'h00 : 8'($urandom_range(255, 16));
    return {op, 32'($urandom)};
  endfunction

  initial begin
    #12;
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // Basic push and issue
    step(1'b1, 40'h01_02_03_04_05, 1'b0, 1'b0, '0, 1'b0);
    chk("t1_valid", 64'(cmd_valid), 64'h1);
    chk("t1_op", 64'(cmd_op), 64'h01);
    chk("t1_a1", 64'(cmd_a1), 64'h02);
    chk("t1_b2", 64'(cmd_b2), 64'h05);
    idle(1'b1, 1'b0);
    chk("t1_inflight", 64'(inflight), 64'h1);
    drain();

    // Illegal opcode filtering
    step(1'b1, 40'h00_11_11_11_11, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 40'h20_22_22_22_22, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 40'h0D_33_33_33_33, 1'b0, 1'b0, '0, 1'b0);
    chk("t2_op", 64'(cmd_op), 64'h0D);
    chk("t2_err", 64'(err_cnt), 64'h2);
    drain();

    // Command FIFO full and ordering
    for (int i = 0; i < 5; i++)
      step(1'b1, {8'(i + 1), 32'h0}, 1'b0, 1'b0, '0, 1'b0);
    chk("t3_full", 64'(in_ready), 64'h0);
    step(1'b1, {8'h05, 32'h0}, 1'b1, 1'b0, '0, 1'b0);
    chk("t3_rdy_back", 64'(in_ready), 64'h1);
    step(1'b1, {8'h05, 32'h0}, 1'b0, 1'b0, '0, 1'b0);
    drain();

    // Credit exhaustion under TX back-pressure
    for (int i = 0; i < 12; i++)
      step(i < 5, {8'(i + 1), 32'h0}, 1'b1, minf > 0, $urandom, 1'b0);
    chk("t4_stall", 64'(cmd_valid), 64'h0);
    chk("t4_resq", 64'(rq.size()), 64'h4);
    idle(1'b0, 1'b1);
    chk("t4_resume", 64'(cmd_valid), 64'h1);
    idle(1'b1, 1'b0);
    drain();

    // Spurious result
    step(1'b0, 40'h0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("t5_proto", 64'(proto_err), 64'h1);
    chk("t5_noout", 64'(out_valid), 64'h0);

    // Reset mid-operation
    step(1'b1, 40'h03_00_00_00_00, 1'b0, 1'b0, '0, 1'b0);
    idle(1'b1, 1'b0);
    step(1'b1, 40'h04_00_00_00_00, 1'b0, 1'b1, 32'h55, 1'b0);
    step(1'b1, 40'h05_00_00_00_00, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 40'h06_00_00_00_00, 1'b0, 1'b0, '0, 1'b0);
    idle(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    mq.delete();
    rq.delete();
    minf = 0;
    merr = 0;
    mproto = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_inflight", 64'(inflight), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 40'h07_01_02_03_04, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_push", 64'(cmd_valid), 64'h1);
    step(1'b0, 40'h0, 1'b0, 1'b1, 32'h77, 1'b0);
    chk("rst_stale_res", 64'(proto_err), 64'h1);

    // Random traffic, long enough for err_cnt to saturate
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) != 0, rnd_ins(), $urandom_range(1) != 0,
           (minf > 0) ? ($urandom_range(1) != 0) : ($urandom_range(49) == 0),
           $urandom, $urandom_range(2) != 0);
    chk("err_sat", 64'(err_cnt), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
